// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// Results land one cycle later in per-requester slots; an undrained full slot blocks its requester.
module alu_share_arb #(
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [63:0]        req_a,
  input  logic [63:0]        req_b,
  input  logic [7:0]         req_op,
  input  logic [1:0]         req_ovctrl,
  input  logic [1:0]         req_wrctrl,
  input  logic [2*TAG_W-1:0] req_tag,
  input  logic [1:0]         flush,
  output logic [31:0]        alu_a,
  output logic [31:0]        alu_b,
  output logic [3:0]         alu_ctrl,
  output logic               alu_ovctrl,
  output logic               alu_wrctrl,
  input  logic [31:0]        alu_result,
  input  logic               alu_ov,
  input  logic               alu_write_reg,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [63:0]        rsp_result,
  output logic [1:0]         rsp_ov,
  output logic [1:0]         rsp_wr,
  output logic [2*TAG_W-1:0] rsp_tag,
  output logic [15:0]        conflict_cnt
);

  logic [1:0]         rsp_valid_q, rsp_valid_d;
  logic [63:0]        rsp_result_q, rsp_result_d;
  logic [1:0]         rsp_ov_q, rsp_ov_d;
  logic [1:0]         rsp_wr_q, rsp_wr_d;
  logic [2*TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic               rr_q, rr_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [1:0]         elig;
  logic [1:0]         grant;

  // A slot being drained this cycle can accept a new result, so ready never waits a bubble.
  always_comb begin
    elig = req_valid & ~flush & (~rsp_valid_q | rsp_ready);
    if (&elig) begin
      grant = rr_q ? 2'b10 : 2'b01;
    end else begin
      grant = elig;
    end
  end

  assign req_ready = grant;

  always_comb begin
    alu_a      = '0;
    alu_b      = '0;
    alu_ctrl   = '0;
    alu_ovctrl = 1'b0;
    alu_wrctrl = 1'b0;
    if (grant[0]) begin
      alu_a      = req_a[31:0];
      alu_b      = req_b[31:0];
      alu_ctrl   = req_op[3:0];
      alu_ovctrl = req_ovctrl[0];
      alu_wrctrl = req_wrctrl[0];
    end else if (grant[1]) begin
      alu_a      = req_a[63:32];
      alu_b      = req_b[63:32];
      alu_ctrl   = req_op[7:4];
      alu_ovctrl = req_ovctrl[1];
      alu_wrctrl = req_wrctrl[1];
    end
  end

  // Flush is applied last so it wins over both drain and capture.
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_ov_d     = rsp_ov_q;
    rsp_wr_d     = rsp_wr_q;
    rsp_tag_d    = rsp_tag_q;
    for (int i = 0; i < 2; i++) begin
      if (rsp_valid_q[i] && rsp_ready[i]) begin
        rsp_valid_d[i] = 1'b0;
      end
      if (grant[i]) begin
        rsp_valid_d[i]              = 1'b1;
        rsp_result_d[32*i +: 32]    = alu_result;
        rsp_ov_d[i]                 = alu_ov;
        rsp_wr_d[i]                 = alu_write_reg;
        rsp_tag_d[TAG_W*i +: TAG_W] = req_tag[TAG_W*i +: TAG_W];
      end
      if (flush[i]) begin
        rsp_valid_d[i] = 1'b0;
      end
    end
    rr_d  = (|grant) ? grant[0] : rr_q;
    cnt_d = ((&elig) && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_ov_q     <= '0;
      rsp_wr_q     <= '0;
      rsp_tag_q    <= '0;
      rr_q         <= 1'b0;
      cnt_q        <= '0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_ov_q     <= rsp_ov_d;
      rsp_wr_q     <= rsp_wr_d;
      rsp_tag_q    <= rsp_tag_d;
      rr_q         <= rr_d;
      cnt_q        <= cnt_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_ov       = rsp_ov_q;
  assign rsp_wr       = rsp_wr_q;
  assign rsp_tag      = rsp_tag_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: a small ALU model on the alu_* ports, directed stimulus,
// and a negedge monitor owning the response scoreboard and the directed-expectation queue.
module tb_alu_share_arb;

  localparam int TAG_W = 4;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                         OP_XOR = 4'd4, OP_MOVZ = 4'd6, OP_MOVN = 4'd7;
  localparam int P_RDY = 0, P_VLD = 1, P_RES0 = 2, P_RES1 = 3, P_OV = 4, P_WR = 5, P_WR1 = 6,
                 P_TAG = 7, P_CNT = 8, P_ALUA = 9, P_CTRL = 10, P_SB0 = 11, P_SB1 = 12;

  typedef struct packed {
    logic [31:0]      res;
    logic             ov;
    logic             wr;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic               clk = 1'b0;
  logic               resetn;
  logic [1:0]         req_valid, req_ready, flush, rsp_valid, rsp_ready, rsp_ov, rsp_wr;
  logic [63:0]        req_a, req_b, rsp_result;
  logic [7:0]         req_op;
  logic [1:0]         req_ovctrl, req_wrctrl;
  logic [2*TAG_W-1:0] req_tag, rsp_tag;
  logic [31:0]        alu_a, alu_b, alu_result;
  logic [3:0]         alu_ctrl;
  logic               alu_ovctrl, alu_wrctrl, alu_ov, alu_write_reg;
  logic [15:0]        conflict_cnt;

  logic [31:0]      ra[2], rb[2], ex_res[2];
  logic [3:0]       rop[2];
  logic             rov[2], rwr[2], ex_ov[2], ex_wr[2];
  logic [TAG_W-1:0] rtag[2];

  assign req_a      = {ra[1], ra[0]};
  assign req_b      = {rb[1], rb[0]};
  assign req_op     = {rop[1], rop[0]};
  assign req_ovctrl = {rov[1], rov[0]};
  assign req_wrctrl = {rwr[1], rwr[0]};
  assign req_tag    = {rtag[1], rtag[0]};

  always #5 clk = ~clk;

  alu_share_arb #(.TAG_W(TAG_W)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .req_op(req_op), .req_ovctrl(req_ovctrl), .req_wrctrl(req_wrctrl), .req_tag(req_tag),
    .flush(flush),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_ovctrl(alu_ovctrl),
    .alu_wrctrl(alu_wrctrl), .alu_result(alu_result), .alu_ov(alu_ov),
    .alu_write_reg(alu_write_reg),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_ov(rsp_ov), .rsp_wr(rsp_wr), .rsp_tag(rsp_tag), .conflict_cnt(conflict_cnt)
  );

  // Shared ALU model
  logic [31:0] alu_sum, alu_diff;
  always_comb begin
    alu_sum       = alu_a + alu_b;
    alu_diff      = alu_a - alu_b;
    alu_result    = '0;
    alu_ov        = 1'b0;
    alu_write_reg = 1'b1;
    case (alu_ctrl)
      OP_ADD: begin
        alu_result = alu_sum;
        alu_ov = alu_ovctrl & (alu_a[31] == alu_b[31]) & (alu_sum[31] != alu_a[31]);
      end
      OP_SUB: begin
        alu_result = alu_diff;
        alu_ov = alu_ovctrl & (alu_a[31] != alu_b[31]) & (alu_diff[31] != alu_a[31]);
      end
      OP_AND: alu_result = alu_a & alu_b;
      OP_OR:  alu_result = alu_a | alu_b;
      OP_XOR: alu_result = alu_a ^ alu_b;
      OP_MOVZ: begin
        alu_result    = (alu_b == 32'd0) ? alu_a : 32'd0;
        alu_write_reg = ~alu_wrctrl | (alu_b == 32'd0);
      end
      OP_MOVN: begin
        alu_result    = (alu_b != 32'd0) ? alu_a : 32'd0;
        alu_write_reg = ~alu_wrctrl | (alu_b != 32'd0);
      end
      default: alu_result = '0;
    endcase
  end

  exp_t        sb0[$], sb1[$];
  string       dq_name[$];
  int          dq_sel[$];
  logic [63:0] dq_exp[$];
  int          dq_rd = 0;
  int          n_cmp = 0, n_err = 0;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] probe(input int sel);
    case (sel)
      P_RDY:  return 64'(req_ready);
      P_VLD:  return 64'(rsp_valid);
      P_RES0: return 64'(rsp_result[31:0]);
      P_RES1: return 64'(rsp_result[63:32]);
      P_OV:   return 64'(rsp_ov);
      P_WR:   return 64'(rsp_wr);
      P_WR1:  return 64'(rsp_wr[1]);
      P_TAG:  return 64'(rsp_tag);
      P_CNT:  return 64'(conflict_cnt);
      P_ALUA: return 64'(alu_a);
      P_CTRL: return 64'(alu_ctrl);
      P_SB0:  return 64'(sb0.size());
      P_SB1:  return 64'(sb1.size());
      default: return '0;
    endcase
  endfunction

  // Monitor: retire slot contents, record new acceptances, then run posted expectations.
  always @(negedge clk) begin
    exp_t e;
    if (!resetn) begin
      sb0.delete();
      sb1.delete();
    end else begin
      if (rsp_valid[0] && (flush[0] || rsp_ready[0])) begin
        if (sb0.size() == 0) cmp("sb0_nonempty", 64'(sb0.size()), 64'd1);
        else begin
          e = sb0.pop_front();
          if (!flush[0]) cmp("slot0", 64'({rsp_result[31:0], rsp_ov[0], rsp_wr[0], rsp_tag[TAG_W-1:0]}), 64'(e));
        end
      end
      if (rsp_valid[1] && (flush[1] || rsp_ready[1])) begin
        if (sb1.size() == 0) cmp("sb1_nonempty", 64'(sb1.size()), 64'd1);
        else begin
          e = sb1.pop_front();
          if (!flush[1]) cmp("slot1", 64'({rsp_result[63:32], rsp_ov[1], rsp_wr[1], rsp_tag[2*TAG_W-1:TAG_W]}), 64'(e));
        end
      end
      if (req_valid[0] && req_ready[0]) begin
        e = {ex_res[0], ex_ov[0], ex_wr[0], rtag[0]};
        sb0.push_back(e);
      end
      if (req_valid[1] && req_ready[1]) begin
        e = {ex_res[1], ex_ov[1], ex_wr[1], rtag[1]};
        sb1.push_back(e);
      end
    end
    while (dq_rd < dq_sel.size()) begin
      cmp(dq_name[dq_rd], probe(dq_sel[dq_rd]), dq_exp[dq_rd]);
      dq_rd++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string nm, input int sel, input logic [63:0] v);
    dq_name.push_back(nm);
    dq_sel.push_back(sel);
    dq_exp.push_back(v);
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic ov, input logic wr, input logic [TAG_W-1:0] tag,
                         input logic [31:0] er, input logic eov, input logic ewr);
    ra[i] = a; rb[i] = b; rop[i] = op; rov[i] = ov; rwr[i] = wr; rtag[i] = tag;
    ex_res[i] = er; ex_ov[i] = eov; ex_wr[i] = ewr;
    req_valid[i] = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; req_valid = '0; rsp_ready = '0; flush = '0;
    for (int i = 0; i < 2; i++) begin
      ra[i] = '0; rb[i] = '0; rop[i] = '0; rov[i] = 1'b0; rwr[i] = 1'b0; rtag[i] = '0;
      ex_res[i] = '0; ex_ov[i] = 1'b0; ex_wr[i] = 1'b0;
    end
    tick(); tick();
    expect_v("rst_valid", P_VLD, 0);  expect_v("rst_res0", P_RES0, 0);
    expect_v("rst_res1", P_RES1, 0);  expect_v("rst_ov", P_OV, 0);
    expect_v("rst_wr", P_WR, 0);      expect_v("rst_tag", P_TAG, 0);
    expect_v("rst_cnt", P_CNT, 0);    expect_v("rst_ready", P_RDY, 0);
    expect_v("idle_alu_a", P_ALUA, 0);
    tick(); resetn = 1'b1;

    // Single ADD with overflow
    tick(); set_req(0, OP_ADD, 32'h7FFF_FFFF, 32'd1, 1'b1, 1'b0, 4'd3, 32'h8000_0000, 1'b1, 1'b1);
    expect_v("add_ready", P_RDY, 2'b01); expect_v("add_alu_a", P_ALUA, 32'h7FFF_FFFF);
    tick(); req_valid = '0;
    expect_v("add_valid", P_VLD, 2'b01); expect_v("add_res", P_RES0, 32'h8000_0000);
    expect_v("add_ov", P_OV, 2'b01);     expect_v("add_tag", P_TAG, 8'h03);
    tick(); rsp_ready = 2'b11;
    tick(); expect_v("add_drained", P_VLD, 2'b00);
    tick(); resetn = 1'b0;
    tick(); resetn = 1'b1;

    // Round robin from rr=0
    tick(); set_req(0, OP_SUB, 32'd10, 32'd4, 1'b0, 1'b0, 4'd1, 32'd6, 1'b0, 1'b1);
    set_req(1, OP_OR, 32'hF0, 32'h0F, 1'b0, 1'b0, 4'd2, 32'hFF, 1'b0, 1'b1);
    expect_v("rr_g1", P_RDY, 2'b01);
    tick(); expect_v("rr_g2", P_RDY, 2'b10); expect_v("rr_ctrl", P_CTRL, OP_OR);
    tick(); expect_v("rr_g3", P_RDY, 2'b01);
    tick(); expect_v("rr_g4", P_RDY, 2'b10);
    tick(); req_valid = '0; expect_v("rr_cnt", P_CNT, 16'd4);

    // Backpressure on slot 0
    tick(); rsp_ready = 2'b10;
    set_req(0, OP_SUB, 32'd5, 32'd3, 1'b0, 1'b0, 4'd4, 32'd2, 1'b0, 1'b1);
    expect_v("bp_ready1", P_RDY, 2'b01);
    tick(); set_req(0, OP_SUB, 32'd9, 32'd1, 1'b0, 1'b0, 4'd5, 32'd8, 1'b0, 1'b1);
    expect_v("bp_stall1", P_RDY, 2'b00); expect_v("bp_valid1", P_VLD, 2'b01);
    expect_v("bp_res2", P_RES0, 32'd2);
    tick(); expect_v("bp_stall2", P_RDY, 2'b00);
    tick(); rsp_ready = 2'b11; expect_v("bp_release", P_RDY, 2'b01);
    tick(); req_valid = '0;
    expect_v("bp_nogap", P_VLD, 2'b01); expect_v("bp_res8", P_RES0, 32'd8);
    tick(); expect_v("bp_empty", P_VLD, 2'b00);

    // MOVZ conditional write on requester 1
    tick(); set_req(1, OP_MOVZ, 32'hABCD, 32'd0, 1'b0, 1'b1, 4'd6, 32'hABCD, 1'b0, 1'b1);
    expect_v("movz_ready1", P_RDY, 2'b10);
    tick(); set_req(1, OP_MOVZ, 32'hABCD, 32'd5, 1'b0, 1'b1, 4'd7, 32'd0, 1'b0, 1'b0);
    expect_v("movz_ready2", P_RDY, 2'b10); expect_v("movz_wr1", P_WR1, 1);
    expect_v("movz_res1", P_RES1, 32'hABCD);
    tick(); req_valid = '0;
    expect_v("movz_wr0", P_WR1, 0); expect_v("movz_res0", P_RES1, 0);
    expect_v("movz_valid", P_VLD, 2'b10);

    // Flush slot 1 while both request
    tick(); rsp_ready = 2'b00;
    set_req(1, OP_XOR, 32'hFF, 32'h0F, 1'b0, 1'b0, 4'd8, 32'hF0, 1'b0, 1'b1);
    expect_v("fl_fill", P_RDY, 2'b10);
    tick(); set_req(1, OP_XOR, 32'd1, 32'd1, 1'b0, 1'b0, 4'd9, 32'd0, 1'b0, 1'b1);
    set_req(0, OP_ADD, 32'd2, 32'd2, 1'b0, 1'b0, 4'hA, 32'd4, 1'b0, 1'b1);
    flush = 2'b10;
    expect_v("fl_grant", P_RDY, 2'b01); expect_v("fl_alu_a", P_ALUA, 32'd2);
    tick(); flush = 2'b00; req_valid = '0; expect_v("fl_valid", P_VLD, 2'b01);
    tick(); rsp_ready = 2'b11;
    tick(); expect_v("fl_empty", P_VLD, 2'b00);
    expect_v("fl_sb0", P_SB0, 0); expect_v("fl_sb1", P_SB1, 0);

    // Asynchronous reset with both slots full
    tick(); rsp_ready = 2'b00;
    set_req(0, OP_SUB, 32'd7, 32'd2, 1'b0, 1'b0, 4'hB, 32'd5, 1'b0, 1'b1);
    set_req(1, OP_AND, 32'hF0, 32'h3C, 1'b0, 1'b0, 4'hC, 32'h30, 1'b0, 1'b1);
    tick();
    tick(); req_valid = '0; expect_v("ar_full", P_VLD, 2'b11);
    @(posedge clk); #2; resetn = 1'b0;
    expect_v("ar_valid", P_VLD, 2'b00); expect_v("ar_res0", P_RES0, 0);
    expect_v("ar_cnt", P_CNT, 0);
    tick(); resetn = 1'b1;

    // Conflict counter saturation
    tick(); rsp_ready = 2'b11;
    set_req(0, OP_ADD, 32'd1, 32'd2, 1'b0, 1'b0, 4'd1, 32'd3, 1'b0, 1'b1);
    set_req(1, OP_AND, 32'hF0, 32'h3C, 1'b0, 1'b0, 4'd2, 32'h30, 1'b0, 1'b1);
    repeat (1000) tick();
    expect_v("sat_1000", P_CNT, 16'd1000);
    repeat (69000) tick();
    expect_v("sat_ffff", P_CNT, 16'hFFFF);
    tick(); req_valid = '0; expect_v("sat_hold", P_CNT, 16'hFFFF);
    tick();
    tick(); expect_v("end_valid", P_VLD, 0);
    expect_v("end_sb0", P_SB0, 0); expect_v("end_sb1", P_SB1, 0);
    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
